// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package disp_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t       SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// Slot timer for the display scanner: owns the in-slot counter, digit index and BLANK/ON phase.
// Outputs are look-ahead: they describe the slot position the next rising edge moves into.
module scan_timer
    import disp_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] idx,
    output logic       phase_on,
    output logic       slot_start_on,
    output logic       frame_end
);

    localparam int CW = (CLK_DIV >= 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("scan_timer: CLK_DIV must be at least 2");
    end
    if ((BLANK_CYCLES < 0) || (BLANK_CYCLES >= CLK_DIV)) begin : g_bad_blank
        $error("scan_timer: BLANK_CYCLES must lie in 0..CLK_DIV-1");
    end

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    scan_state_t   r_state;

    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    scan_state_t   w_state_nxt;
    logic          w_in_blank;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_idx_nxt = r_idx;
        if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + 3'd1;
        end
    end

    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign w_in_blank = 1'b0;
    end else begin : g_blank
        assign w_in_blank = (w_cnt_nxt < BLANK_END);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BLANK:   if (!w_in_blank) w_state_nxt = ON;
            ON:      if (w_in_blank)  w_state_nxt = BLANK;
            default: w_state_nxt = BLANK;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_state <= BLANK;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Entering ON from BLANK, or crossing a slot boundary when there is no blank gap.
    assign slot_start_on = (w_state_nxt == ON) && ((r_state == BLANK) || (w_cnt_nxt == BLANK_END));
    assign phase_on      = (w_state_nxt == ON);
    assign idx           = w_idx_nxt;
    assign frame_end     = (w_idx_nxt == 3'd7) && (w_cnt_nxt == CNT_MAX);

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexes eight active-low segment patterns onto one segment bus with
// active-low anodes, a blanking gap per slot, a per-digit enable mask and a frame pulse.
module display_scanner
    import disp_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [7:0] d4,
    input  logic [7:0] d5,
    input  logic [7:0] d6,
    input  logic [7:0] d7,
    input  logic [7:0] digit_en,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_tick
);

    logic [2:0] w_idx;
    logic       w_phase_on;
    logic       w_slot_start_on;
    logic       w_frame_end;

    scan_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clock         (clock),
        .reset         (reset),
        .idx           (w_idx),
        .phase_on      (w_phase_on),
        .slot_start_on (w_slot_start_on),
        .frame_end     (w_frame_end)
    );

    seg_t       r_snap;
    logic       r_en;
    logic [7:0] r_an;
    seg_t       r_seg;
    logic       r_frame_tick;

    seg_t       w_d_sel;
    seg_t       w_snap_nxt;
    logic       w_en_nxt;

    always_comb begin
        w_d_sel = d0;
        case (w_idx)
            3'd1:    w_d_sel = d1;
            3'd2:    w_d_sel = d2;
            3'd3:    w_d_sel = d3;
            3'd4:    w_d_sel = d4;
            3'd5:    w_d_sel = d5;
            3'd6:    w_d_sel = d6;
            3'd7:    w_d_sel = d7;
            default: w_d_sel = d0;
        endcase
    end

    // Pattern and enable are frozen for the whole lit window of a slot.
    always_comb begin
        w_snap_nxt = r_snap;
        w_en_nxt   = r_en;
        if (w_slot_start_on) begin
            w_snap_nxt = w_d_sel;
            w_en_nxt   = digit_en[w_idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_snap       <= SEG_BLANK;
            r_en         <= 1'b0;
            r_an         <= AN_OFF;
            r_seg        <= SEG_BLANK;
            r_frame_tick <= 1'b0;
        end else begin
            r_snap       <= w_snap_nxt;
            r_en         <= w_en_nxt;
            r_frame_tick <= w_frame_end;
            if (w_phase_on && w_en_nxt) begin
                r_an  <= ~(8'd1 << w_idx);
                r_seg <= w_snap_nxt;
            end else begin
                r_an  <= AN_OFF;
                r_seg <= SEG_BLANK;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Downstream of the calculator top.
- Takes the calculator's eight registered 8-bit segment patterns (d0..d7) and time-multiplexes them onto one shared 8-bit segment bus with eight active-low digit anodes.
- Adds a blanking gap between digits to suppress ghosting, and provides a per-digit enable mask.
- Emits a one-cycle frame pulse for bench and system synchronisation.

Parameters:
- CLK_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be ≥2; elaboration error otherwise.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Must be < CLK_DIV; elaboration error otherwise. 0 is legal.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- d0..d7  input  8 each  segment patterns {dp,g,f,e,d,c,b,a}, active-low, from the calculator top
- digit_en  input  8  bit k=1 allows digit k to light
- an  output  8  digit anodes, active-low, bit k = digit k
- seg  output  8  segment bus, active-low, same bit order as d*
- frame_tick  output  1  one-cycle pulse in the last cycle of digit 7's slot

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- All outputs are registered.
- Reset (asynchronous, effective immediately, including mid-slot):
  - an=8'hFF, seg=8'hFF, frame_tick=0.
  - Internal slot counter cnt=0, digit index idx=0, state=BLANK.
- Slot timing:
  - Slot k spans CLK_DIV cycles. The first slot (digit 0) starts at the first rising edge after reset deasserts.
  - cnt counts 0..CLK_DIV-1. When cnt==CLK_DIV-1, cnt returns to 0 and idx advances; idx wraps 7→0.
  - Frame period = 8×CLK_DIV cycles.
- State machine:
  - BLANK: an=8'hFF, seg=8'hFF. Occupies the first BLANK_CYCLES cycles of each slot. With BLANK_CYCLES=0 the state is skipped entirely and digits abut.
  - ON: an=~(8'b1<<idx), seg=snapshot. Occupies the remaining CLK_DIV-BLANK_CYCLES cycles.
  - Transition ON→BLANK at each slot end (or ON→ON of the next digit when BLANK_CYCLES=0).
- Snapshot:
  - d[idx] is captured into an internal register at the edge that enters ON for that slot.
  - Changes on d* during ON are not visible until that digit's next slot.
- Enable mask:
  - digit_en[idx] is sampled at the same edge as the snapshot.
  - If it is 0, the slot stays fully blank (an=8'hFF, seg=8'hFF) but still consumes CLK_DIV cycles, so brightness of enabled digits is unchanged.
  - Mask changes take effect at the next slot boundary, never mid-slot.
- frame_tick:
  - High for exactly the one cycle where idx==7 and cnt==CLK_DIV-1.
  - Never high during reset.
- Invariant: at most one an bit is low in any cycle.

Decomposition:
- Shared package disp_pkg contains:
  - typedef seg_t = logic[7:0]
  - constants SEG_BLANK=8'hFF and AN_OFF=8'hFF
  - enum scan_state_t {BLANK, ON}
- One sub-module, scan_timer:
  - Parameterised by CLK_DIV and BLANK_CYCLES.
  - Owns cnt and idx.
  - Outputs idx[2:0], phase_on, slot_start_on (one-cycle, at the BLANK→ON edge) and frame_end.
- The top level holds the snapshot/mask register and the output registers.

Test Plan:
1. Reset behaviour: assert reset between clock edges while digit 3 is ON → an=8'hFF, seg=8'hFF and frame_tick=0 immediately, before the next edge. Deassert → digit 0 slot restarts at cnt=0.
2. Scan order (CLK_DIV=4, BLANK_CYCLES=1, digit_en=8'hFF, d0=8'hC0, d1=8'hF9, d2=8'hA4 … d7=8'hF8):
   - an=8'hFE with seg=8'hC0 on cycles 1–3 after reset release; an=8'hFF on cycle 4.
   - an=8'hFD with seg=8'hF9 on cycles 5–7; continuing in order through an=8'h7F with seg=8'hF8 on cycles 29–31.
   - frame_tick high only on cycles 31 and 63.
3. Snapshot hold: change d2 from 8'hA4 to 8'h80 during digit 2's ON phase → seg stays 8'hA4 for the rest of that slot; 8'h80 appears in digit 2's slot of the next frame.
4. Enable mask: digit_en=8'h01 → only digit 0 lights (an=8'hFE on cycles 1–3 of each frame); all other slots show an=8'hFF, seg=8'hFF; frame_tick period stays 32 cycles.
5. No blanking: BLANK_CYCLES=0, CLK_DIV=4 → an is never 8'hFF after the first edge; it steps FE→FD→…→7F every 4 cycles.
6. One-hot invariant: run ≥3 frames with random d*, digit_en changes and mid-frame resets → assertion that an has at most one zero bit every cycle, and seg==8'hFF whenever an==8'hFF.
